cpu_mul_combine: RTL and testbench
==================================

Name: cpu_mul_combine

Overview:
Downstream consumer of the CPU multiply cell. It takes the three registered 16x16 partial products (lo*lo, lo*hi, hi*lo) that are valid in M stage. It combines them over two pipeline registers (A, W) into the low 32 bits of the 32x32 product, and carries a valid bit and destination register tag alongside. It exposes pending-destination outputs so the hazard logic can stall dependent instructions.

Parameters:
DST_W, 5, width of destination register tag
CROSS_W, 16, width of retained cross-term sum (upper half of result)

Ports:
clk  in  1  pipeline clock
reset_n  in  1  asynchronous active-low reset
M_en  in  1  M-stage advance; same enable that clocks the multiply cell
A_en  in  1  A-stage advance (M->A)
W_en  in  1  W-stage advance (A->W)
E_mul_valid  in  1  E stage holds a valid MUL instruction
E_dst  in  DST_W  destination register of E-stage MUL
M_mul_cell_p1  in  32  src1[15:0]*src2[15:0], valid in M
M_mul_cell_p2  in  32  src1[15:0]*src2[31:16], valid in M
M_mul_cell_p3  in  32  src1[31:16]*src2[15:0], valid in M
pipe_flush  in  1  kill in-flight MULs in M and A
W_mul_valid  out  1  W_mul_result is a valid retiring result
W_mul_dst  out  DST_W  destination tag of retiring result
W_mul_result  out  32  low 32 bits of product
mul_pending  out  1  valid MUL in M or A
M_mul_dst_pend  out  DST_W  tag in M (meaningful when M valid)
A_mul_dst_pend  out  DST_W  tag in A (meaningful when A valid)

Behaviour:
- Reset (async, reset_n=0): all valid bits 0, all tags 0, A_p1=0, A_cross=0, W_mul_result=0. Outputs read 0 in the same cycle reset asserts.
- M stage: on clk with M_en=1, M_vld<=E_mul_valid, M_dst<=E_dst. This is aligned with the cell's internal register, so the products belong to the tag held in M. M_en=0 holds.
- A stage: on clk with A_en=1:
  - A_vld<=M_vld
  - A_dst<=M_dst
  - A_p1<=M_mul_cell_p1
  - A_cross<=(p2[15:0]+p3[15:0]) mod 2^16
  - The upper halves of p2/p3 are discarded; they affect bits >=32 only.
- W stage: on clk with W_en=1:
  - W_mul_valid<=A_vld
  - W_mul_dst<=A_dst
  - W_mul_result<=(A_p1+{A_cross,16'h0}) mod 2^32
- Latency: E issue to W_mul_valid is three enabled edges (M, A, W), assuming no stalls.
- Signedness: the low word is identical for signed and unsigned operands, so no sign handling is needed.
- Stall: any stage whose enable is 0 holds all of its registers. Downstream-stage enables are the pipeline's responsibility, so no bubble insertion is needed here.
- Flush: pipe_flush=1 at a clock edge clears M_vld and A_vld, overriding a simultaneous enable load. W is unaffected, because the instruction already in W retires.
- Simultaneous M_en and pipe_flush: the new E entry is dropped, giving M_vld=0.
- Data registers are not cleared by flush; only valid bits are.
- mul_pending = M_vld | A_vld, combinational from registers.
- Reset mid-operation clears all valids immediately; no partial result is emitted after reset.

Decomposition:
- Shared CPU package: DST_W, result width 32, half-word width 16.
- No sub-module: the adder and the three register stages live in one module.
- Optional natural sub-module: cpu_mul_stage_reg, a generic enable/flush/valid register slice used for M and A.

Test Plan:
- Operands 0x00010003 * 0x00020005, cell outputs p1=15, p2=6, p3=5, all enables 1 -> three edges later W_mul_valid=1, W_mul_result=0x000B000F.
- 0xFFFFFFFF * 0xFFFFFFFF (p1=p2=p3=0xFFFE0001) -> W_mul_result=0x00000001, with cross-term wrap at 16 bits.
- Back-to-back MULs with dst 3 then 7, A_en=0 for 2 cycles after the first reaches A:
  - A holds dst 3.
  - W_mul_valid stays 0 during the stall.
  - Results then retire in order with the correct tags.
  - mul_pending=1 throughout.
- pipe_flush pulsed while MULs sit in M and A, W holding a valid result -> W result retires; next two W cycles have W_mul_valid=0.
- Reset asserted asynchronously mid-pipeline with 3 MULs in flight -> all valids and W_mul_result are 0 immediately. After release, a new MUL 7*6 (p1=42, p2=p3=0) yields 0x0000002A.
- M_en and pipe_flush in the same edge with E_mul_valid=1 -> M_vld=0, and no result ever reaches W.

Source files
------------

// File: rtl/cpu_mul_combine_pkg.sv
// Shared constants for the CPU multiply datapath.
package cpu_mul_combine_pkg;

  // Destination register tag width (32-entry register file).
  localparam int MUL_DST_W   = 5;
  // Width of the retained product word.
  localparam int MUL_RES_W   = 32;
  // Half-word width of the 16x16 partial products' operands.
  localparam int MUL_HALF_W  = 16;
  // Width of the cross-term sum that lands in the upper half of the result.
  localparam int MUL_CROSS_W = MUL_RES_W - MUL_HALF_W;

endpackage : cpu_mul_combine_pkg

// File: rtl/cpu_mul_stage_reg.sv
// Generic pipeline register slice: a valid bit plus a payload.
// The enable loads both; flush clears only the valid bit and wins over the
// enable. The payload is left alone on flush so that a killed entry costs no
// extra toggling on the wide data path.
module cpu_mul_stage_reg
  import cpu_mul_combine_pkg::*;
#(
  parameter int DATA_W = MUL_DST_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              flush,
  input  logic              vld_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              vld_out,
  output logic [DATA_W-1:0] data_out
);

  logic              vld_q;
  logic              vld_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  // Next-state: hold unless enabled; flush drops the valid bit regardless.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (en) begin
      vld_d  = vld_in;
      data_d = data_in;
    end
    if (flush) begin
      vld_d = 1'b0;
    end
  end

  // State register with asynchronous clear of both valid and payload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_out  = vld_q;
  assign data_out = data_q;

endmodule : cpu_mul_stage_reg

// File: rtl/cpu_mul_combine.sv
// Combines the three registered 16x16 partial products of the multiply cell
// into the low 32 bits of the 32x32 product over the A and W stages, tracking
// valid and destination tag from M through W for the hazard logic.
//
// Only lo*lo and the low halves of the two cross terms contribute to the low
// word; hi*hi and the cross-term upper halves only affect bits >= 32. The low
// word is the same for signed and unsigned operands, so no sign fix-up exists.
module cpu_mul_combine
  import cpu_mul_combine_pkg::*;
#(
  parameter int DST_W   = MUL_DST_W,
  parameter int CROSS_W = MUL_CROSS_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             M_en,
  input  logic             A_en,
  input  logic             W_en,
  input  logic             E_mul_valid,
  input  logic [DST_W-1:0] E_dst,
  input  logic [31:0]      M_mul_cell_p1,
  input  logic [31:0]      M_mul_cell_p2,
  input  logic [31:0]      M_mul_cell_p3,
  input  logic             pipe_flush,
  output logic             W_mul_valid,
  output logic [DST_W-1:0] W_mul_dst,
  output logic [31:0]      W_mul_result,
  output logic             mul_pending,
  output logic [DST_W-1:0] M_mul_dst_pend,
  output logic [DST_W-1:0] A_mul_dst_pend
);

  localparam int RES_W  = MUL_RES_W;
  localparam int LO_W   = RES_W - CROSS_W;
  localparam int A_DATA = DST_W + RES_W + CROSS_W;

  // M stage: valid/tag registered on the same enable as the cell's internal
  // product register, so the products on the M_mul_cell_* inputs belong here.
  logic             m_vld;
  logic [DST_W-1:0] m_dst;

  cpu_mul_stage_reg #(
    .DATA_W (DST_W)
  ) u_m_stage (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (M_en),
    .flush    (pipe_flush),
    .vld_in   (E_mul_valid),
    .data_in  (E_dst),
    .vld_out  (m_vld),
    .data_out (m_dst)
  );

  // Cross-term sum, truncated to the bits that survive into the low word.
  logic [CROSS_W-1:0] m_cross;

  always_comb begin
    m_cross = M_mul_cell_p2[CROSS_W-1:0] + M_mul_cell_p3[CROSS_W-1:0];
  end

  // Upper cross-term bits are architecturally irrelevant to the low word.
  logic unused_cross_hi;
  assign unused_cross_hi = ^{M_mul_cell_p2[RES_W-1:CROSS_W],
                             M_mul_cell_p3[RES_W-1:CROSS_W]};

  // A stage: tag, lo*lo product and the folded cross term.
  logic               a_vld;
  logic [DST_W-1:0]   a_dst;
  logic [RES_W-1:0]   a_p1;
  logic [CROSS_W-1:0] a_cross;
  logic [A_DATA-1:0]  a_data;

  cpu_mul_stage_reg #(
    .DATA_W (A_DATA)
  ) u_a_stage (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (A_en),
    .flush    (pipe_flush),
    .vld_in   (m_vld),
    .data_in  ({m_dst, M_mul_cell_p1, m_cross}),
    .vld_out  (a_vld),
    .data_out (a_data)
  );

  assign {a_dst, a_p1, a_cross} = a_data;

  // W stage: final add. Not touched by flush; whatever sits in W retires.
  logic             w_vld_q;
  logic             w_vld_d;
  logic [DST_W-1:0] w_dst_q;
  logic [DST_W-1:0] w_dst_d;
  logic [RES_W-1:0] w_res_q;
  logic [RES_W-1:0] w_res_d;

  // W next-state: load the combined low word on W_en, otherwise hold.
  always_comb begin
    w_vld_d = w_vld_q;
    w_dst_d = w_dst_q;
    w_res_d = w_res_q;
    if (W_en) begin
      w_vld_d = a_vld;
      w_dst_d = a_dst;
      w_res_d = a_p1 + {a_cross, {LO_W{1'b0}}};
    end
  end

  // W register, cleared asynchronously so no stale result escapes a reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_vld_q <= 1'b0;
      w_dst_q <= '0;
      w_res_q <= '0;
    end else begin
      w_vld_q <= w_vld_d;
      w_dst_q <= w_dst_d;
      w_res_q <= w_res_d;
    end
  end

  // Retirement and hazard-tracking outputs, all straight from registers.
  assign W_mul_valid    = w_vld_q;
  assign W_mul_dst      = w_dst_q;
  assign W_mul_result   = w_res_q;
  assign mul_pending    = m_vld | a_vld;
  assign M_mul_dst_pend = m_dst;
  assign A_mul_dst_pend = a_dst;

endmodule : cpu_mul_combine

// File: tb/tb_cpu_mul_combine.sv
// Directed bench for cpu_mul_combine: inputs change 1 ns after each rising
// edge, outputs are sampled at the same point.
module tb_cpu_mul_combine;

  logic        clk;
  logic        reset_n;
  logic        M_en;
  logic        A_en;
  logic        W_en;
  logic        E_mul_valid;
  logic [4:0]  E_dst;
  logic [31:0] M_mul_cell_p1;
  logic [31:0] M_mul_cell_p2;
  logic [31:0] M_mul_cell_p3;
  logic        pipe_flush;
  logic        W_mul_valid;
  logic [4:0]  W_mul_dst;
  logic [31:0] W_mul_result;
  logic        mul_pending;
  logic [4:0]  M_mul_dst_pend;
  logic [4:0]  A_mul_dst_pend;

  int n_cmp;
  int n_err;

  cpu_mul_combine dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .M_en           (M_en),
    .A_en           (A_en),
    .W_en           (W_en),
    .E_mul_valid    (E_mul_valid),
    .E_dst          (E_dst),
    .M_mul_cell_p1  (M_mul_cell_p1),
    .M_mul_cell_p2  (M_mul_cell_p2),
    .M_mul_cell_p3  (M_mul_cell_p3),
    .pipe_flush     (pipe_flush),
    .W_mul_valid    (W_mul_valid),
    .W_mul_dst      (W_mul_dst),
    .W_mul_result   (W_mul_result),
    .mul_pending    (mul_pending),
    .M_mul_dst_pend (M_mul_dst_pend),
    .A_mul_dst_pend (A_mul_dst_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p(input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3);
    M_mul_cell_p1 = p1;
    M_mul_cell_p2 = p2;
    M_mul_cell_p3 = p3;
  endtask

  task automatic issue(input logic vld, input logic [4:0] dst);
    E_mul_valid = vld;
    E_dst       = dst;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    M_en = 1'b0; A_en = 1'b0; W_en = 1'b0;
    pipe_flush = 1'b0;
    issue(1'b0, 5'd0);
    set_p(32'h0, 32'h0, 32'h0);

    // Reset state
    #12;
    chk("rst_w_vld",   32'(W_mul_valid),    32'd0);
    chk("rst_w_dst",   32'(W_mul_dst),      32'd0);
    chk("rst_w_res",   W_mul_result,        32'd0);
    chk("rst_pending", 32'(mul_pending),    32'd0);
    chk("rst_m_dst",   32'(M_mul_dst_pend), 32'd0);
    chk("rst_a_dst",   32'(A_mul_dst_pend), 32'd0);
    #2 reset_n = 1'b1;
    M_en = 1'b1; A_en = 1'b1; W_en = 1'b1;

    // 0x00010003 * 0x00020005: p1=15, p2=6, p3=5 -> 0x000B000F
    issue(1'b1, 5'd4);
    tick();
    issue(1'b0, 5'd0);
    set_p(32'd15, 32'd6, 32'd5);
    chk("t1_pending_m", 32'(mul_pending),    32'd1);
    chk("t1_m_dst",     32'(M_mul_dst_pend), 32'd4);
    chk("t1_w_vld_m",   32'(W_mul_valid),    32'd0);
    tick();
    set_p(32'h0, 32'h0, 32'h0);
    chk("t1_a_dst",     32'(A_mul_dst_pend), 32'd4);
    chk("t1_w_vld_a",   32'(W_mul_valid),    32'd0);
    tick();
    chk("t1_w_vld",     32'(W_mul_valid),    32'd1);
    chk("t1_w_dst",     32'(W_mul_dst),      32'd4);
    chk("t1_w_res",     W_mul_result,        32'h000B000F);
    chk("t1_pending_w", 32'(mul_pending),    32'd0);
    tick();
    chk("t1_w_drain",   32'(W_mul_valid),    32'd0);

    // 0xFFFFFFFF squared: cross term 1+1, carry out of bit 31 dropped
    issue(1'b1, 5'd9);
    tick();
    issue(1'b0, 5'd0);
    set_p(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001);
    tick();
    set_p(32'h0, 32'h0, 32'h0);
    tick();
    chk("t2_w_vld", 32'(W_mul_valid), 32'd1);
    chk("t2_w_dst", 32'(W_mul_dst),   32'd9);
    chk("t2_w_res", W_mul_result,     32'h00000001);
    tick();

    // Back-to-back dst 3 then 7, pipeline stalled 2 cycles with 3 in A
    issue(1'b1, 5'd3);
    tick();
    issue(1'b1, 5'd7);
    set_p(32'h10, 32'h1, 32'h0);
    tick();
    issue(1'b0, 5'd0);
    set_p(32'h20, 32'h0, 32'h2);
    M_en = 1'b0; A_en = 1'b0; W_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t3_stall_a_dst",   32'(A_mul_dst_pend), 32'd3);
      chk("t3_stall_m_dst",   32'(M_mul_dst_pend), 32'd7);
      chk("t3_stall_w_vld",   32'(W_mul_valid),    32'd0);
      chk("t3_stall_pending", 32'(mul_pending),    32'd1);
    end
    M_en = 1'b1; A_en = 1'b1; W_en = 1'b1;
    tick();
    chk("t3_first_vld",     32'(W_mul_valid), 32'd1);
    chk("t3_first_dst",     32'(W_mul_dst),   32'd3);
    chk("t3_first_res",     W_mul_result,     32'h00010010);
    chk("t3_first_pending", 32'(mul_pending), 32'd1);
    set_p(32'h0, 32'h0, 32'h0);
    tick();
    chk("t3_second_vld",     32'(W_mul_valid), 32'd1);
    chk("t3_second_dst",     32'(W_mul_dst),   32'd7);
    chk("t3_second_res",     W_mul_result,     32'h00020020);
    chk("t3_second_pending", 32'(mul_pending), 32'd0);
    tick();

    // Flush with entries in M and A while W holds a valid result
    issue(1'b1, 5'd1);
    tick();
    issue(1'b1, 5'd2);
    set_p(32'd1, 32'd0, 32'd0);
    tick();
    issue(1'b1, 5'd5);
    set_p(32'd2, 32'd0, 32'd0);
    tick();
    issue(1'b0, 5'd0);
    set_p(32'd3, 32'd0, 32'd0);
    chk("t4_w_before", 32'(W_mul_dst), 32'd1);
    pipe_flush = 1'b1;
    W_en = 1'b0;
    tick();
    pipe_flush = 1'b0;
    W_en = 1'b1;
    set_p(32'h0, 32'h0, 32'h0);
    chk("t4_w_retire_vld", 32'(W_mul_valid), 32'd1);
    chk("t4_w_retire_dst", 32'(W_mul_dst),   32'd1);
    chk("t4_w_retire_res", W_mul_result,     32'd1);
    chk("t4_pending",      32'(mul_pending), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t4_w_killed", 32'(W_mul_valid), 32'd0);
    end

    // Asynchronous reset with three MULs in flight
    issue(1'b1, 5'd1);
    tick();
    issue(1'b1, 5'd2);
    set_p(32'd11, 32'd0, 32'd0);
    tick();
    issue(1'b1, 5'd3);
    set_p(32'd22, 32'd0, 32'd0);
    tick();
    chk("t5_w_full", 32'(W_mul_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_w_vld",   32'(W_mul_valid),    32'd0);
    chk("t5_rst_w_res",   W_mul_result,        32'd0);
    chk("t5_rst_w_dst",   32'(W_mul_dst),      32'd0);
    chk("t5_rst_pending", 32'(mul_pending),    32'd0);
    chk("t5_rst_a_dst",   32'(A_mul_dst_pend), 32'd0);
    #2 reset_n = 1'b1;
    issue(1'b1, 5'd6);
    set_p(32'h0, 32'h0, 32'h0);
    tick();
    chk("t5_post_w_vld", 32'(W_mul_valid), 32'd0);
    issue(1'b0, 5'd0);
    set_p(32'd42, 32'd0, 32'd0);
    tick();
    set_p(32'h0, 32'h0, 32'h0);
    tick();
    chk("t5_7x6_vld", 32'(W_mul_valid), 32'd1);
    chk("t5_7x6_dst", 32'(W_mul_dst),   32'd6);
    chk("t5_7x6_res", W_mul_result,     32'h0000002A);
    tick();

    // M_en and flush together: new entry dropped, tag still captured
    issue(1'b1, 5'd12);
    pipe_flush = 1'b1;
    tick();
    issue(1'b0, 5'd0);
    pipe_flush = 1'b0;
    chk("t6_pending", 32'(mul_pending),    32'd0);
    chk("t6_m_dst",   32'(M_mul_dst_pend), 32'd12);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_w_never", 32'(W_mul_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_cpu_mul_combine
